// File: rtl/ext_pkg.sv
// Shared types for the immediate-extension pipeline stage.
// Config macro: IMM_EXT_BRSHL2_EN (enables the branch word-offset shift in mode 3).
package ext_pkg;

  localparam int EXT_MODE_W = 2;

  typedef enum logic [EXT_MODE_W-1:0] {
    EXT_ZERO   = 2'd0,
    EXT_SIGN   = 2'd1,
    EXT_UPPER  = 2'd2,
    EXT_BRSHL2 = 2'd3
  } ext_mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate widener: (imm, mode) -> OUT_W result.
// Config macro: IMM_EXT_BRSHL2_EN. When undefined, mode 3 aliases SIGN and no shifter exists.
module imm_ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       imm,
  input  logic [EXT_MODE_W-1:0] mode,
  output logic [OUT_W-1:0]      result
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] upper;

  // Size casts handle OUT_W == IN_W without zero-width replications.
  assign zext  = OUT_W'(imm);
  assign sext  = OUT_W'($signed(imm));
  // A shift by the full width yields zero, which is the correct UPPER result when OUT_W == IN_W.
  assign upper = zext << IN_W;

`ifdef IMM_EXT_BRSHL2_EN
  logic [OUT_W-1:0] brshl2;
  assign brshl2 = sext << 2;
`endif

  // Select the extension for the requested mode.
  always_comb begin
    result = zext;
    case (ext_mode_t'(mode))
      EXT_ZERO:   result = zext;
      EXT_SIGN:   result = sext;
      EXT_UPPER:  result = upper;
`ifdef IMM_EXT_BRSHL2_EN
      EXT_BRSHL2: result = brshl2;
`else
      EXT_BRSHL2: result = sext;
`endif
      default:    result = zext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate-extension stage between decode and execute.
// Main register drives the output bus; a skid register absorbs one item while
// execute stalls, so in_ready is purely registered.
// Config macro: IMM_EXT_BRSHL2_EN (passed through to imm_ext_core).
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [EXT_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag
);

  logic             main_valid;
  logic [OUT_W-1:0] main_data;
  logic [TAG_W-1:0] main_tag;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;

  logic [OUT_W-1:0] ext_result;
  logic             accept;
  logic             main_free;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm    (in_imm),
    .mode   (in_mode),
    .result (ext_result)
  );

  // Handshake terms; main_free means the main register is empty or draining this edge.
  always_comb begin
    accept    = in_valid & ~skid_valid;
    main_free = ~main_valid | out_ready;
  end

  // Main/skid storage. Priority: reset, then flush, then normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_tag   <= '0;
    end else if (flush) begin
      // Any transfer on the bus this cycle still completes downstream; the stage just empties.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Skid full implies in_ready was low, so no new item competes for main.
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= ext_result;
        main_tag   <= in_tag;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= ext_result;
      skid_tag   <= in_tag;
    end
  end

  // Output bus comes straight from registers.
  always_comb begin
    in_ready  = ~skid_valid;
    out_valid = main_valid;
    out_data  = main_data;
    out_tag   = main_tag;
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: the driver pushes hand-computed expectations
// on each accepted input; a negedge monitor pops and compares every output transfer.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

`ifdef IMM_EXT_BRSHL2_EN
  localparam logic [31:0] EXP_BR_FFFD = 32'hFFFF_FFF4;
`else
  localparam logic [31:0] EXP_BR_FFFD = 32'hFFFF_FFFD;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every bus transfer must match the head of the scoreboard.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got data %h tag %0d, expected none", out_data, out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[36:5]);
          chk("out_tag", {27'd0, out_tag}, {27'd0, e[4:0]});
        end
      end
    end
  end

  // Single offer; called at posedge+1 so in_ready reflects this cycle.
  task automatic offer(input logic [1:0] m, input logic [15:0] imm, input logic [4:0] tag,
                       input logic [31:0] exp, output bit acc);
    in_valid = 1'b1;
    in_mode  = m;
    in_imm   = imm;
    in_tag   = tag;
    acc      = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (acc) exp_q.push_back({exp, tag});
  endtask

  task automatic send(input logic [1:0] m, input logic [15:0] imm, input logic [4:0] tag,
                      input logic [31:0] exp);
    bit acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) offer(m, imm, tag, exp, acc);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: tag %0d not accepted, expected accept within 20 cycles", tag);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit acc;
    logic [31:0] held_data;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0;
    out_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic modes with one-cycle latency check on the first item
    out_ready = 1'b1;
    offer(2'd1, 16'hFFE7, 5'd1, 32'hFFFF_FFE7, acc);
    chk("lat_accept", {31'd0, acc}, 32'd1);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_data", out_data, 32'hFFFF_FFE7);
    send(2'd1, 16'h0004, 5'd2, 32'h0000_0004);
    send(2'd0, 16'hFFFD, 5'd3, 32'h0000_FFFD);
    send(2'd2, 16'h1234, 5'd4, 32'h1234_0000);
    send(2'd3, 16'hFFFD, 5'd5, EXP_BR_FFFD);
    send(2'd1, 16'h7FFF, 5'd6, 32'h0000_7FFF);
    send(2'd0, 16'h8000, 5'd7, 32'h0000_8000);
    send(2'd2, 16'hFFFF, 5'd8, 32'hFFFF_0000);
    send(2'd3, 16'h0001, 5'd9, `ifdef IMM_EXT_BRSHL2_EN 32'h0000_0004 `else 32'h0000_0001 `endif);
    idle(2);

    // Backpressure: two accepted, third refused, then ordered drain
    out_ready = 1'b0;
    offer(2'd1, 16'h0010, 5'd10, 32'h0000_0010, acc);
    chk("bp_acc1", {31'd0, acc}, 32'd1);
    offer(2'd0, 16'hF011, 5'd11, 32'h0000_F011, acc);
    chk("bp_acc2", {31'd0, acc}, 32'd1);
    offer(2'd2, 16'h0012, 5'd12, 32'h0012_0000, acc);
    chk("bp_acc3_refused", {31'd0, acc}, 32'd0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    held_data = out_data;
    idle(2);
    chk("bp_stable_data", out_data, held_data);
    chk("bp_stable_tag", {27'd0, out_tag}, 32'd10);
    out_ready = 1'b1;
    send(2'd2, 16'h0012, 5'd12, 32'h0012_0000);
    idle(3);

    // Flush with both entries full; item offered in flush cycle is dropped
    out_ready = 1'b0;
    send(2'd1, 16'h0020, 5'd20, 32'h0000_0020);
    send(2'd1, 16'h0021, 5'd21, 32'h0000_0021);
    chk("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; in_valid = 1'b1; in_mode = 2'd1; in_imm = 16'h0022; in_tag = 5'd22;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);

    // Flush with only main full: in_ready is high but the offer must still be dropped
    send(2'd1, 16'h0023, 5'd23, 32'h0000_0023);
    flush = 1'b1; in_valid = 1'b1; in_mode = 2'd1; in_imm = 16'h0024; in_tag = 5'd24;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("fl2_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    idle(3);

    // Flush concurrent with a downstream transfer: that transfer still counts
    send(2'd0, 16'h0030, 5'd30, 32'h0000_0030);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    chk("fl3_out_valid", {31'd0, out_valid}, 32'd0);
    idle(2);

    // Reset mid-stream with both entries full
    out_ready = 1'b0;
    send(2'd1, 16'hFF40, 5'd17, 32'hFFFF_FF40);
    send(2'd1, 16'h0041, 5'd18, 32'h0000_0041);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_out_data", out_data, 32'd0);
    chk("rst2_out_tag", {27'd0, out_tag}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);

    // Post-reset traffic and bounded drain
    out_ready = 1'b1;
    send(2'd1, 16'h8001, 5'd25, 32'hFFFF_8001);
    send(2'd2, 16'h00AB, 5'd26, 32'h00AB_0000);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
